// File: rtl/encoder_pkg.sv
// Shared types and helpers for the registered priority encoder family.
// Helpers work on a fixed maximum width; callers zero-extend narrower vectors.
package encoder_pkg;

    localparam int MAX_N = 64;
    localparam int MAX_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic multi_hot(input logic [MAX_N-1:0] v);
        return (v & (v - MAX_N'(1))) != '0;
    endfunction

    function automatic logic [MAX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: highest set index in fixed mode, or the first set
// index at or above ptr (wrapping to the lowest set index) in round-robin mode.
module prio_pick
    import encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         rr_en,
    output logic [N-1:0] grant,
    output logic [W-1:0] code,
    output logic         any
);

    logic [N-1:0]     upper;
    logic [N-1:0]     fix_grant;
    logic [N-1:0]     lo_upper;
    logic [N-1:0]     lo_all;
    logic [N-1:0]     rr_grant;
    logic [MAX_W-1:0] idx_full;

    always_comb begin
        upper     = '0;
        fix_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(ptr)) begin
                upper[i] = req[i];
            end
            // Later iterations overwrite earlier ones, so the highest index wins.
            if (req[i]) begin
                fix_grant    = '0;
                fix_grant[i] = 1'b1;
            end
        end

        lo_upper = upper & (~upper + N'(1));
        lo_all   = req & (~req + N'(1));
        rr_grant = (upper != '0) ? lo_upper : lo_all;

        grant    = rr_en ? rr_grant : fix_grant;
        idx_full = onehot_to_idx(MAX_N'(grant));
        code     = W'(idx_full);
        any      = |req;
    end

endmodule

// File: rtl/prio_encoder_seq.sv
// Registered N-to-log2(N) priority encoder holding one result per sample
// until it is consumed through a valid/ready handshake.
module prio_encoder_seq
    import encoder_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = $clog2(N),
    parameter int RR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         sample,
    input  logic         out_ready,
    output logic         valid,
    output logic [W-1:0] code,
    output logic [N-1:0] grant,
    output logic         none,
    output logic         multi
);

    state_t       state;
    state_t       state_next;
    logic         load;
    logic         handshake;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_succ;
    logic [W-1:0] ptr_eff;

    logic [N-1:0] pick_grant;
    logic [W-1:0] pick_code;
    logic         pick_any;

    logic [W-1:0] code_p1;
    logic [N-1:0] grant_p1;
    logic         none_p1;
    logic         multi_p1;

    assign valid     = (state == HOLD);
    assign handshake = valid && out_ready;

    // Explicit wrap so non-power-of-two N returns to 0 rather than overflowing.
    assign ptr_succ = (code_p1 == W'(N - 1)) ? '0 : code_p1 + W'(1);

    // A back-to-back load must already see the pointer advanced by the result
    // being consumed on the same edge.
    assign ptr_eff = ((RR != 0) && handshake && !none_p1) ? ptr_succ : ptr;

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_eff),
        .rr_en (RR != 0),
        .grant (pick_grant),
        .code  (pick_code),
        .any   (pick_any)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (sample) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (sample) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- stage p1: held result ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            code_p1  <= '0;
            grant_p1 <= '0;
            none_p1  <= 1'b0;
            multi_p1 <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_eff;
            if (load) begin
                code_p1  <= pick_code;
                grant_p1 <= pick_grant;
                none_p1  <= !pick_any;
                multi_p1 <= multi_hot(MAX_N'(req));
            end
        end
    end

    assign code  = code_p1;
    assign grant = grant_p1;
    assign none  = none_p1;
    assign multi = multi_p1;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_p1));

    a_none_zero: assert property (@(posedge clk) disable iff (!rst_n)
        none_p1 |-> (grant_p1 == '0 && code_p1 == '0 && !multi_p1));

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Directed bench for prio_encoder_seq: fixed N=8, round-robin N=8,
// round-robin N=5 and fixed N=4 instances share one clock and reset.
module tb_prio_encoder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // fixed priority, N=8
    logic [7:0] req8f;
    logic       smp8f, rdy8f, v8f, n8f, m8f;
    logic [2:0] c8f;
    logic [7:0] g8f;

    // round-robin, N=8
    logic [7:0] req8r;
    logic       smp8r, rdy8r, v8r, n8r, m8r;
    logic [2:0] c8r;
    logic [7:0] g8r;

    // round-robin, N=5
    logic [4:0] req5;
    logic       smp5, rdy5, v5, n5, m5;
    logic [2:0] c5;
    logic [4:0] g5;

    // fixed priority, N=4
    logic [3:0] req4;
    logic       smp4, rdy4, v4, n4, m4;
    logic [1:0] c4;
    logic [3:0] g4;

    prio_encoder_seq #(.N(8), .RR(0)) dut8f (
        .clk(clk), .rst_n(rst_n), .req(req8f), .sample(smp8f), .out_ready(rdy8f),
        .valid(v8f), .code(c8f), .grant(g8f), .none(n8f), .multi(m8f));

    prio_encoder_seq #(.N(8), .RR(1)) dut8r (
        .clk(clk), .rst_n(rst_n), .req(req8r), .sample(smp8r), .out_ready(rdy8r),
        .valid(v8r), .code(c8r), .grant(g8r), .none(n8r), .multi(m8r));

    prio_encoder_seq #(.N(5), .RR(1)) dut5r (
        .clk(clk), .rst_n(rst_n), .req(req5), .sample(smp5), .out_ready(rdy5),
        .valid(v5), .code(c5), .grant(g5), .none(n5), .multi(m5));

    prio_encoder_seq #(.N(4), .RR(0)) dut4f (
        .clk(clk), .rst_n(rst_n), .req(req4), .sample(smp4), .out_ready(rdy4),
        .valid(v4), .code(c4), .grant(g4), .none(n4), .multi(m4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp5(input logic [4:0] r);
        req5 = r; smp5 = 1'b1; rdy5 = 1'b0;
        tick();
        smp5 = 1'b0;
    endtask

    task automatic hs5();
        rdy5 = 1'b1;
        tick();
        rdy5 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req8f = 8'hFF; smp8f = 1'b1; rdy8f = 1'b1;
        req8r = 8'hFF; smp8r = 1'b1; rdy8r = 1'b1;
        req5  = 5'h1F; smp5  = 1'b1; rdy5  = 1'b1;
        req4  = 4'hF;  smp4  = 1'b1; rdy4  = 1'b1;
        tick();
        tick();
        checks++;
        if ({v8f, c8f, g8f, n8f, m8f} !== 14'b0) begin
            failures++;
            $display("FAIL reset_8f got=%b exp=0", {v8f, c8f, g8f, n8f, m8f});
        end
        checks++;
        if ({v8r, c8r, g8r, n8r, m8r} !== 14'b0) begin
            failures++;
            $display("FAIL reset_8r got=%b exp=0", {v8r, c8r, g8r, n8r, m8r});
        end
        checks++;
        if ({v5, c5, g5, n5, m5} !== 11'b0) begin
            failures++;
            $display("FAIL reset_5r got=%b exp=0", {v5, c5, g5, n5, m5});
        end
        checks++;
        if ({v4, c4, g4, n4, m4} !== 9'b0) begin
            failures++;
            $display("FAIL reset_4f got=%b exp=0", {v4, c4, g4, n4, m4});
        end
        rst_n = 1'b1;
        smp8f = 1'b0; rdy8f = 1'b0;
        smp8r = 1'b0; rdy8r = 1'b0;
        smp5  = 1'b0; rdy5  = 1'b0;
        smp4  = 1'b0; rdy4  = 1'b0;
        tick();
        checks++;
        if ({v8f, v8r, v5, v4} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle_valid got=%b exp=0000", {v8f, v8r, v5, v4});
        end
    endtask

    task automatic test_fixed_hold();
        logic [7:0] noise [3];
        noise[0] = 8'h01; noise[1] = 8'hFF; noise[2] = 8'h00;
        req8f = 8'b0010_0110; smp8f = 1'b1; rdy8f = 1'b0;
        tick();
        smp8f = 1'b0;
        checks++;
        if ({v8f, c8f, g8f, n8f, m8f} !== {1'b1, 3'd5, 8'h20, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL fixed_first got=%b exp=%b", {v8f, c8f, g8f, n8f, m8f},
                     {1'b1, 3'd5, 8'h20, 1'b0, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            req8f = noise[i]; smp8f = 1'b1;
            tick();
            checks++;
            if ({v8f, c8f, g8f, n8f, m8f} !== {1'b1, 3'd5, 8'h20, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL fixed_hold%0d got=%b exp=%b", i, {v8f, c8f, g8f, n8f, m8f},
                         {1'b1, 3'd5, 8'h20, 1'b0, 1'b1});
            end
        end
        smp8f = 1'b0; rdy8f = 1'b1;
        tick();
        rdy8f = 1'b0;
        checks++;
        if (v8f !== 1'b0) begin
            failures++;
            $display("FAIL fixed_consume valid got=%b exp=0", v8f);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_c;
        logic [7:0] exp_g;
        req8r = 8'hFF; smp8r = 1'b1; rdy8r = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp_c = 3'(k % 8);
            exp_g = 8'b1 << (k % 8);
            checks++;
            if ({v8r, c8r, g8r, n8r, m8r} !== {1'b1, exp_c, exp_g, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL rr_b2b%0d got=%b exp=%b", k, {v8r, c8r, g8r, n8r, m8r},
                         {1'b1, exp_c, exp_g, 1'b0, 1'b1});
            end
        end
        smp8r = 1'b0;
        tick();
        rdy8r = 1'b0;
        checks++;
        if (v8r !== 1'b0) begin
            failures++;
            $display("FAIL rr_b2b_drain valid got=%b exp=0", v8r);
        end
    endtask

    task automatic test_rr_wrap();
        samp5(5'b01000);
        checks++;
        if ({v5, c5, g5, n5, m5} !== {1'b1, 3'd3, 5'b01000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL wrap_code3 got=%b exp=%b", {v5, c5, g5, n5, m5},
                     {1'b1, 3'd3, 5'b01000, 1'b0, 1'b0});
        end
        hs5();
        checks++;
        if (v5 !== 1'b0) begin
            failures++;
            $display("FAIL wrap_consume valid got=%b exp=0", v5);
        end
        samp5(5'b00011);
        checks++;
        if ({v5, c5, g5, n5, m5} !== {1'b1, 3'd0, 5'b00001, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL wrap_ptr4 got=%b exp=%b", {v5, c5, g5, n5, m5},
                     {1'b1, 3'd0, 5'b00001, 1'b0, 1'b1});
        end
        hs5();
        samp5(5'b00011);
        checks++;
        if ({c5, g5} !== {3'd1, 5'b00010}) begin
            failures++;
            $display("FAIL wrap_ptr1 got=%b exp=%b", {c5, g5}, {3'd1, 5'b00010});
        end
        hs5();
        samp5(5'b10000);
        checks++;
        if ({c5, g5} !== {3'd4, 5'b10000}) begin
            failures++;
            $display("FAIL wrap_top got=%b exp=%b", {c5, g5}, {3'd4, 5'b10000});
        end
        hs5();
        samp5(5'b11111);
        checks++;
        if ({c5, g5, m5} !== {3'd0, 5'b00001, 1'b1}) begin
            failures++;
            $display("FAIL wrap_to_zero got=%b exp=%b", {c5, g5, m5}, {3'd0, 5'b00001, 1'b1});
        end
        hs5();
    endtask

    task automatic test_empty();
        samp5(5'b00000);
        checks++;
        if ({v5, c5, g5, n5, m5} !== {1'b1, 3'd0, 5'b00000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL empty_result got=%b exp=%b", {v5, c5, g5, n5, m5},
                     {1'b1, 3'd0, 5'b00000, 1'b1, 1'b0});
        end
        hs5();
        samp5(5'b11111);
        checks++;
        if ({v5, c5, g5, n5} !== {1'b1, 3'd1, 5'b00010, 1'b0}) begin
            failures++;
            $display("FAIL empty_ptr_kept got=%b exp=%b", {v5, c5, g5, n5},
                     {1'b1, 3'd1, 5'b00010, 1'b0});
        end
        hs5();
    endtask

    task automatic test_fixed_sweep();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r = 4'b1 << i;
            req4 = r; smp4 = 1'b1;
            tick();
            smp4 = 1'b0;
            checks++;
            if ({v4, c4, g4, n4, m4} !== {1'b1, 2'(i), r, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL sweep%0d got=%b exp=%b", i, {v4, c4, g4, n4, m4},
                         {1'b1, 2'(i), r, 1'b0, 1'b0});
            end
            rdy4 = 1'b1;
            tick();
            rdy4 = 1'b0;
        end
        req4 = 4'b0110; smp4 = 1'b1;
        tick();
        smp4 = 1'b0;
        checks++;
        if ({v4, c4, g4, n4, m4} !== {1'b1, 2'd2, 4'b0100, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sweep_multi got=%b exp=%b", {v4, c4, g4, n4, m4},
                     {1'b1, 2'd2, 4'b0100, 1'b0, 1'b1});
        end
        rdy4 = 1'b1;
        tick();
        rdy4 = 1'b0;
        checks++;
        if (v4 !== 1'b0) begin
            failures++;
            $display("FAIL sweep_consume valid got=%b exp=0", v4);
        end
    endtask

    task automatic test_reset_mid();
        req8r = 8'h0C; smp8r = 1'b1; rdy8r = 1'b0;
        tick();
        smp8r = 1'b0;
        checks++;
        if ({v8r, c8r, g8r, m8r} !== {1'b1, 3'd2, 8'h04, 1'b1}) begin
            failures++;
            $display("FAIL midrst_pre got=%b exp=%b", {v8r, c8r, g8r, m8r},
                     {1'b1, 3'd2, 8'h04, 1'b1});
        end
        rst_n = 1'b0; req8r = 8'hFF; smp8r = 1'b1; rdy8r = 1'b1;
        tick();
        checks++;
        if ({v8r, c8r, g8r, n8r, m8r} !== 14'b0) begin
            failures++;
            $display("FAIL midrst_clear got=%b exp=0", {v8r, c8r, g8r, n8r, m8r});
        end
        rst_n = 1'b1; smp8r = 1'b0;
        tick();
        checks++;
        if (v8r !== 1'b0) begin
            failures++;
            $display("FAIL midrst_discard valid got=%b exp=0", v8r);
        end
        req8r = 8'hC0; smp8r = 1'b1;
        tick();
        smp8r = 1'b0;
        checks++;
        if ({v8r, c8r, g8r} !== {1'b1, 3'd6, 8'h40}) begin
            failures++;
            $display("FAIL midrst_ptr0 got=%b exp=%b", {v8r, c8r, g8r}, {1'b1, 3'd6, 8'h40});
        end
        tick();
        rdy8r = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        req8f = '0; smp8f = 1'b0; rdy8f = 1'b0;
        req8r = '0; smp8r = 1'b0; rdy8r = 1'b0;
        req5  = '0; smp5  = 1'b0; rdy5  = 1'b0;
        req4  = '0; smp4  = 1'b0; rdy4  = 1'b0;
        test_reset();
        test_fixed_hold();
        test_back_to_back();
        test_rr_wrap();
        test_empty();
        test_fixed_sweep();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prio_encoder_seq.md
# prio_encoder_seq

Registered, parametrised N-to-log2(N) priority encoder with a valid/ready output handshake. Each sampled request vector produces one held result that stays stable until it is consumed. Fixed-priority or round-robin selection is chosen per instance, and the result flags empty and multi-hot inputs. Successor to the 4-to-2 combinational encoders; it feeds interrupt/request dispatch logic downstream.

## Interface
Parameters:
- N, 8, number of request lines (≥2)
- W, $clog2(N), code width (derived; not overridden)
- RR, 0, 0 = fixed priority (highest index wins), 1 = round-robin

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req  in  N  request vector
- sample  in  1  capture strobe for req
- out_ready  in  1  consumer accepts current result
- valid  out  1  result held and valid
- code  out  W  index of winning request
- grant  out  N  one-hot of winner (all-zero when none)
- none  out  1  sampled req was all-zero
- multi  out  1  sampled req had more than one bit set

One clock; reset is synchronous and active-low.

## Operation
- FSM states: IDLE and HOLD.
- IDLE, sample=1: capture the result of the current req, assert valid, go to HOLD. sample=0: stay.
- HOLD: valid, code, grant, none and multi are frozen.
  - sample while out_ready=0: ignored.
  - out_ready=1, sample=0: valid clears; go to IDLE.
  - out_ready=1, sample=1: back-to-back. Load the new result; valid stays 1; stay in HOLD.
- Fixed mode: the winner is the highest set index.
- RR mode: search upward from pointer ptr (W bits), wrapping modulo N. The winner is the first set bit at index ≥ptr, else the lowest set bit.
- ptr update: ptr ← (winner+1) mod N on each handshake (valid & out_ready) where none=0. N not a power of two: the wrap is explicit, not a bit overflow. ptr is unused when RR=0.
- req=0 at sample: none=1, code=0, grant=0, multi=0. This is still a valid result requiring a handshake.
- multi=1 iff popcount(req)≥2 at sample. It is independent of mode.
- req changes between samples have no effect on outputs.

## Timing
- Latency: sample at edge k → valid=1 with result at edge k+1.
- Handshake completes on an edge where valid & out_ready. valid=0 one edge later unless sample is high on that same edge.
- Throughput: one result per cycle with sample and out_ready held high.
- Reset (rst_n=0 at edge): valid=0, code=0, grant=0, none=0, multi=0, ptr=0, state IDLE. Reset dominates sample and out_ready, and drops a held result mid-handshake.
- out_ready while valid=0: no effect.

## Structure
- Package encoder_pkg holds:
  - state enum {IDLE, HOLD}
  - popcount-≥2 function
  - one-hot-to-index function, reused by the older encoders' successors
- Sub-module prio_pick: purely combinational masked priority picker.
  - Inputs: req, ptr, rr_en.
  - Outputs: grant, code, any.
  - Instantiated once; the parent holds all state.

## Test plan
- Fixed mode, N=8: sample req=8'b0010_0110 → next cycle valid=1, code=5, grant=8'h20, multi=1; hold out_ready=0 for 3 cycles with req changing → outputs unchanged.
- RR mode, N=8, req=8'hFF sampled and consumed 9 times back-to-back (sample=out_ready=1) → codes 0,1,…,7,0; valid never drops.
- RR wrap, N=5: ptr=4 (after a code-3 grant), sample req=5'b00011 → code=0; after handshake ptr=1.
- Empty input: sample req=0 → valid=1, none=1, code=0, grant=0; handshake → ptr unchanged.
- Reset while in HOLD with valid=1 → next edge all outputs 0, ptr=0; a sample in the reset cycle is discarded.
- Single-bit sweep, fixed mode, N=4: req=1,2,4,8 → code=0,1,2,3, multi=0 (matches the 4-to-2 truth table).
